// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request / result bundle for seq_alu.
// master drives the request, slave returns ready and the registered result.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       control;
  logic [WIDTH-1:0] dataInACC;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] pc;
  logic             ready;
  logic [WIDTH-1:0] dataOut;
  logic             outValid;
  logic             carry;
  logic             zero;

  modport master (
    output start, control, dataInACC, dataIn, pc,
    input  ready, dataOut, outValid, carry, zero
  );

  modport slave (
    input  start, control, dataInACC, dataIn, pc,
    output ready, dataOut, outValid, carry, zero
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU, single-cycle ops plus bit-serial shift-left.
// Define SEQ_ALU_MUL_EN to compile in the shift-add multiplier (code 100).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic             pend;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, p;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;
  logic             cry, zf, vld;
  logic             accept, is_mul, multi;
  logic [CW-1:0]    shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s_res;
  logic             s_cry;

`ifdef SEQ_ALU_MUL_EN
  logic               mul;
  logic [2*WIDTH-1:0] prod, mcand, psum;
  logic [WIDTH-1:0]   mplier;

  assign is_mul = bus.control == 3'b100;
  assign psum   = prod + (mplier[0] ? mcand : '0);
`else
  assign is_mul = 1'b0;
`endif

  assign accept = bus.start && state == IDLE;
  assign multi  = is_mul || bus.control == 3'b101;
  assign shamt  = CW'(32'(bus.dataIn) % 32'(WIDTH));

  assign bus.ready    = state == IDLE;
  assign bus.dataOut  = res;
  assign bus.carry    = cry;
  assign bus.zero     = zf;
  assign bus.outValid = vld;

  // single-cycle ops evaluate from the operands captured one edge earlier
  always_comb begin
    sum   = '0;
    s_res = '0;
    s_cry = 1'b0;
    unique case (op)
      3'b000: begin
        sum   = {1'b0, a} + {1'b0, b};
        s_res = sum[WIDTH-1:0];
        s_cry = sum[WIDTH];
      end
      3'b001: s_res = ~(a & b);
      3'b010: s_res = (a != '0) ? p : b;
      3'b011: s_res = {{(WIDTH-1){1'b0}}, a < b};
      default: s_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= 1'b0;
      op     <= '0;
      a      <= '0;
      b      <= '0;
      p      <= '0;
      sh     <= '0;
      cnt    <= '0;
      res    <= '0;
      cry    <= 1'b0;
      zf     <= 1'b1;
      vld    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mul    <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      vld  <= 1'b0;
      pend <= 1'b0;
      if (pend) begin
        res <= s_res;
        cry <= s_cry;
        zf  <= s_res == '0;
        vld <= 1'b1;
      end
      if (state == BUSY) begin
`ifdef SEQ_ALU_MUL_EN
        if (mul) begin
          prod   <= psum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            res   <= psum[WIDTH-1:0];
            cry   <= |psum[2*WIDTH-1:WIDTH];
            zf    <= psum[WIDTH-1:0] == '0;
            vld   <= 1'b1;
            state <= IDLE;
          end
        end else
`endif
        if (cnt == '0) begin
          res   <= sh;
          cry   <= 1'b0;
          zf    <= sh == '0;
          vld   <= 1'b1;
          state <= IDLE;
        end else begin
          sh  <= sh << 1;
          cnt <= cnt - 1'b1;
        end
      end
      if (accept) begin
        if (multi) begin
          state <= BUSY;
          sh    <= bus.dataInACC;
`ifdef SEQ_ALU_MUL_EN
          mul    <= is_mul;
          prod   <= '0;
          mcand  <= {{WIDTH{1'b0}}, bus.dataInACC};
          mplier <= bus.dataIn;
          cnt    <= is_mul ? '0 : shamt;
`else
          cnt    <= shamt;
`endif
        end else begin
          pend <= 1'b1;
          op   <= bus.control;
          a    <= bus.dataInACC;
          b    <= bus.dataIn;
          p    <= bus.pc;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu (WIDTH=8)
// against a plain-arithmetic reference model.
module tb_seq_alu;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seq_alu_if #(.WIDTH(8)) bus();

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] c, input logic [7:0] a, b, p,
                                output logic [7:0] r, output logic cy, output int lat);
    int s;
    int n;
    r   = 8'h00;
    cy  = 1'b0;
    lat = 1;
    case (c)
      3'd0: begin
        s  = int'(a) + int'(b);
        r  = 8'(s);
        cy = s > 255;
      end
      3'd1: r = ~(a & b);
      3'd2: r = (a != 0) ? p : b;
      3'd3: r = (a < b) ? 8'd1 : 8'd0;
`ifdef SEQ_ALU_MUL_EN
      3'd4: begin
        s   = int'(a) * int'(b);
        r   = 8'(s);
        cy  = s > 255;
        lat = 8;
      end
`endif
      3'd5: begin
        n   = int'(b) % 8;
        r   = 8'(int'(a) << n);
        lat = n + 1;
      end
      default: r = 8'h00;
    endcase
  endfunction

  // issue one op, scramble inputs after acceptance, wait for the result
  task automatic do_op(input logic [2:0] c, input logic [7:0] a, b, p, input bit poke,
                       output int lat, output logic [7:0] r, output logic cy,
                       output logic z, output logic rdy, output logic vnext);
    bus.start = 1'b1;
    bus.control = c;
    bus.dataInACC = a;
    bus.dataIn = b;
    bus.pc = p;
    @(posedge clk); #1;
    bus.start = poke;
    bus.control = 3'd0;
    bus.dataInACC = 8'($urandom);
    bus.dataIn = 8'($urandom);
    bus.pc = 8'($urandom);
    lat = -1;
    r = 8'h00;
    cy = 1'b0;
    z = 1'b0;
    rdy = bus.ready;
    vnext = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.outValid) begin
        lat = e;
        r = bus.dataOut;
        cy = bus.carry;
        z = bus.zero;
        break;
      end
      rdy = rdy | bus.ready;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      vnext = bus.outValid;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.control = 3'd0;
    bus.dataInACC = 8'h00;
    bus.dataIn = 8'h00;
    bus.pc = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.dataOut !== 8'h00) begin
      fails++; $display("FAIL reset_dataOut got %h want 00", bus.dataOut);
    end
    tests++;
    if (bus.carry !== 1'b0 || bus.zero !== 1'b1) begin
      fails++; $display("FAIL reset_flags got c=%b z=%b want c=0 z=1", bus.carry, bus.zero);
    end
    tests++;
    if (bus.outValid !== 1'b0 || bus.ready !== 1'b1) begin
      fails++; $display("FAIL reset_hs got v=%b rdy=%b want v=0 rdy=1", bus.outValid, bus.ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0] r, er, a, b;
    logic cy, ecy, z, rdy, vn;
    int lat, elat;
    do_op(3'd0, 8'hF0, 8'h20, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h10 || cy !== 1'b1 || lat != 1) begin
      fails++; $display("FAIL add_dir got r=%h c=%b lat=%0d want r=10 c=1 lat=1", r, cy, lat);
    end
    tests++;
    if (rdy !== 1'b1 || vn !== 1'b0) begin
      fails++; $display("FAIL add_hs got rdy=%b vnext=%b want rdy=1 vnext=0", rdy, vn);
    end
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = (i == 0) ? 8'(-a) : 8'($urandom);
      model(3'd0, a, b, 8'h00, er, ecy, elat);
      do_op(3'd0, a, b, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
      tests++;
      if (r !== er || cy !== ecy || z !== (er == 0) || lat != elat) begin
        fails++;
        $display("FAIL add_rnd a=%h b=%h got r=%h c=%b z=%b lat=%0d want r=%h c=%b lat=%0d",
                 a, b, r, cy, z, lat, er, ecy, elat);
      end
    end
  endtask

  task automatic test_logic;
    logic [7:0] r, er, a, b, p;
    logic cy, ecy, z, rdy, vn;
    logic [2:0] c;
    int lat, elat;
    do_op(3'd2, 8'h00, 8'h33, 8'h7C, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h33 || lat != 1) begin
      fails++; $display("FAIL br_a0 got %h lat=%0d want 33 lat=1", r, lat);
    end
    do_op(3'd2, 8'h01, 8'h33, 8'h7C, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h7C) begin
      fails++; $display("FAIL br_a1 got %h want 7c", r);
    end
    do_op(3'd1, 8'hFF, 8'h0F, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'hF0 || cy !== 1'b0) begin
      fails++; $display("FAIL nand_dir got %h c=%b want f0 c=0", r, cy);
    end
    for (int i = 0; i < 24; i++) begin
      c = 3'($urandom_range(1, 7));
`ifdef SEQ_ALU_MUL_EN
      if (c == 3'd4) c = 3'd6;
`endif
      if (c == 3'd5) c = 3'd7;
      a = (i % 4 == 0) ? 8'h00 : 8'($urandom);
      b = (i % 5 == 0) ? a : 8'($urandom);
      p = 8'($urandom);
      model(c, a, b, p, er, ecy, elat);
      do_op(c, a, b, p, 1'b0, lat, r, cy, z, rdy, vn);
      tests++;
      if (r !== er || cy !== ecy || z !== (er == 0) || lat != elat || rdy !== 1'b1) begin
        fails++;
        $display("FAIL logic_rnd op=%0d a=%h b=%h got r=%h c=%b lat=%0d rdy=%b want r=%h c=%b lat=%0d",
                 c, a, b, r, cy, lat, rdy, er, ecy, elat);
      end
    end
  endtask

  task automatic test_shift;
    logic [7:0] r, er, a, b;
    logic cy, ecy, z, rdy, vn;
    int lat, elat;
    bit pk;
    do_op(3'd5, 8'h81, 8'h0A, 8'h00, 1'b1, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h04 || lat != 3 || rdy !== 1'b0 || vn !== 1'b0) begin
      fails++;
      $display("FAIL shl_n2 got r=%h lat=%0d rdy=%b vnext=%b want r=04 lat=3 rdy=0 vnext=0",
               r, lat, rdy, vn);
    end
    do_op(3'd5, 8'h81, 8'h08, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h81 || lat != 1) begin
      fails++; $display("FAIL shl_n0 got r=%h lat=%0d want r=81 lat=1", r, lat);
    end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      model(3'd5, a, b, 8'h00, er, ecy, elat);
      pk = elat > 1;
      do_op(3'd5, a, b, 8'h00, pk, lat, r, cy, z, rdy, vn);
      tests++;
      if (r !== er || cy !== 1'b0 || z !== (er == 0) || lat != elat || vn !== 1'b0
          || (pk && rdy !== 1'b0)) begin
        fails++;
        $display("FAIL shl_rnd a=%h b=%h got r=%h lat=%0d rdy=%b vnext=%b want r=%h lat=%0d",
                 a, b, r, lat, rdy, vn, er, elat);
      end
    end
  endtask

  task automatic test_mul;
    logic [7:0] r, er, a, b;
    logic cy, ecy, z, rdy, vn;
    int lat, elat;
`ifdef SEQ_ALU_MUL_EN
    do_op(3'd4, 8'h10, 8'h11, 8'h00, 1'b1, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h10 || cy !== 1'b1 || lat != 8 || rdy !== 1'b0 || vn !== 1'b0) begin
      fails++;
      $display("FAIL mul_dir got r=%h c=%b lat=%0d rdy=%b vnext=%b want r=10 c=1 lat=8 rdy=0 vnext=0",
               r, cy, lat, rdy, vn);
    end
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = (i < 3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      model(3'd4, a, b, 8'h00, er, ecy, elat);
      do_op(3'd4, a, b, 8'h00, 1'b1, lat, r, cy, z, rdy, vn);
      tests++;
      if (r !== er || cy !== ecy || z !== (er == 0) || lat != elat || rdy !== 1'b0) begin
        fails++;
        $display("FAIL mul_rnd a=%h b=%h got r=%h c=%b lat=%0d want r=%h c=%b lat=%0d",
                 a, b, r, cy, lat, er, ecy, elat);
      end
    end
`else
    do_op(3'd4, 8'h10, 8'h11, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h00 || cy !== 1'b0 || z !== 1'b1 || lat != 1 || rdy !== 1'b1) begin
      fails++;
      $display("FAIL mul_off got r=%h c=%b z=%b lat=%0d rdy=%b want r=00 c=0 z=1 lat=1 rdy=1",
               r, cy, z, lat, rdy);
    end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      model(3'd4, a, b, 8'h00, er, ecy, elat);
      do_op(3'd4, a, b, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
      tests++;
      if (r !== er || cy !== ecy || lat != elat) begin
        fails++; $display("FAIL mul_off_rnd got r=%h lat=%0d want r=%h lat=%0d", r, lat, er, elat);
      end
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_r[$];
    logic       exp_c[$];
    logic [7:0] a, b, p, er;
    logic [2:0] c;
    logic ecy;
    int elat;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        c = 3'($urandom_range(0, 3));
        if (i % 7 == 6) c = 3'd6;
        a = 8'($urandom);
        b = 8'($urandom);
        p = 8'($urandom);
        model(c, a, b, p, er, ecy, elat);
        exp_r.push_back(er);
        exp_c.push_back(ecy);
        bus.start = 1'b1;
        bus.control = c;
        bus.dataInACC = a;
        bus.dataIn = b;
        bus.pc = p;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        er = exp_r.pop_front();
        ecy = exp_c.pop_front();
        tests++;
        if (bus.outValid !== 1'b1 || bus.dataOut !== er || bus.carry !== ecy
            || bus.ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_%0d got v=%b r=%h c=%b rdy=%b want v=1 r=%h c=%b rdy=1",
                   i, bus.outValid, bus.dataOut, bus.carry, bus.ready, er, ecy);
        end
      end
    end
    @(posedge clk); #1;
    tests++;
    if (bus.outValid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail got v=%b want 0", bus.outValid);
    end
  endtask

  task automatic test_reset_busy;
    logic [7:0] r;
    logic cy, z, rdy, vn, saw;
    int lat;
    do_op(3'd0, 8'h12, 8'h01, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    bus.start = 1'b1;
`ifdef SEQ_ALU_MUL_EN
    bus.control = 3'd4;
    bus.dataInACC = 8'h10;
    bus.dataIn = 8'h11;
`else
    bus.control = 3'd5;
    bus.dataInACC = 8'h81;
    bus.dataIn = 8'h07;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw = saw | bus.outValid;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.dataOut !== 8'h00 || bus.zero !== 1'b1 || bus.carry !== 1'b0
        || bus.outValid !== 1'b0 || bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_busy got r=%h z=%b c=%b v=%b rdy=%b want r=00 z=1 c=0 v=0 rdy=1",
               bus.dataOut, bus.zero, bus.carry, bus.outValid, bus.ready);
    end
    @(posedge clk); #1;
    saw = saw | bus.outValid;
    rst_n = 1'b1;
    do_op(3'd3, 8'd3, 8'd5, 8'h00, 1'b0, lat, r, cy, z, rdy, vn);
    tests++;
    if (r !== 8'h01 || lat != 1 || z !== 1'b0 || saw !== 1'b0 || vn !== 1'b0) begin
      fails++;
      $display("FAIL rst_slt got r=%h lat=%0d z=%b stray=%b want r=01 lat=1 z=0 stray=0",
               r, lat, z, saw | vn);
    end
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw = saw | bus.outValid;
    end
    tests++;
    if (saw !== 1'b0 || bus.dataOut !== 8'h01) begin
      fails++; $display("FAIL rst_idle got stray=%b r=%h want stray=0 r=01", saw, bus.dataOut);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_add;
    test_logic;
    test_shift;
    test_mul;
    test_back_to_back;
    test_reset_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the datapath width of operands and result; legal values 4 to 32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request an operation; it is accepted only when start=1 and ready=1 on a rising edge.
REQ-005 control  input  3  SHALL select the operation: 000 add, 001 nand, 010 branch-select, 011 set-less-than, 100 multiply, 101 shift-left, 110/111 reserved.
REQ-006 dataInACC  input  WIDTH  SHALL be the accumulator operand A.
REQ-007 dataIn  input  WIDTH  SHALL be the second operand B.
REQ-008 pc  input  WIDTH  SHALL be the program-counter value used by branch-select.
REQ-009 ready  output  1  SHALL be 1 when the block can accept an operation.
REQ-010 dataOut  output  WIDTH  SHALL carry the registered result.
REQ-011 outValid  output  1  SHALL pulse high for exactly one cycle when dataOut is updated with a new result.
REQ-012 carry  output  1  SHALL carry the add carry-out or the multiply overflow flag; 0 for other ops.
REQ-013 zero  output  1  SHALL be 1 when the registered dataOut equals 0.

Function
REQ-014 The block SHALL capture control, dataInACC, dataIn and pc on acceptance; later input changes SHALL NOT affect that operation.
REQ-015 The FSM SHALL have states IDLE and BUSY; IDLE->BUSY on acceptance of a multi-cycle op; BUSY->IDLE on the cycle its result is written.
REQ-016 ready SHALL be 1 in IDLE and 0 in BUSY; start while ready=0 SHALL be ignored, not queued.
REQ-017 Ops 000, 001, 010, 011, 110 and 111 SHALL be single-cycle: result in dataOut and outValid=1 on the edge after acceptance, with ready remaining 1.
REQ-018 Back-to-back single-cycle ops SHALL be accepted on consecutive cycles, giving consecutive outValid pulses.
REQ-019 Add SHALL produce (A+B) mod 2^WIDTH, with carry set to bit WIDTH of the full sum.
REQ-020 Nand SHALL produce ~(A&B) bitwise.
REQ-021 Branch-select SHALL produce pc when A!=0, otherwise B.
REQ-022 Set-less-than SHALL compare A and B unsigned and produce 1 when A<B, otherwise 0, zero-extended to WIDTH.
REQ-023 Multiply SHALL be computed shift-add, one bit of B per cycle.
REQ-024 Multiply SHALL produce the low WIDTH bits of A*B with outValid exactly WIDTH cycles after acceptance.
REQ-025 Multiply SHALL set carry to 1 when the high WIDTH bits of A*B are nonzero, otherwise 0.
REQ-026 Shift-left SHALL shift A left by n = B mod WIDTH, one bit per cycle, zero-filling.
REQ-027 Shift-left SHALL produce outValid n+1 cycles after acceptance; n=0 SHALL return A after 1 cycle.
REQ-028 Reserved codes SHALL produce 0, with outValid still pulsing.
REQ-029 dataOut, carry and zero SHALL hold their values between results; outValid SHALL be 0 otherwise.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state IDLE, dataOut=0, carry=0, zero=1, outValid=0 and ready=1.
REQ-031 Reset during BUSY SHALL abort the operation with no outValid; the first edge after release SHALL be able to accept a start.

Configuration
REQ-032 Macro SEQ_ALU_MUL_EN defined: the multiplier of REQ-023 to REQ-025 SHALL be compiled in.
REQ-033 Macro SEQ_ALU_MUL_EN undefined: the multiplier SHALL be compiled out and code 100 SHALL behave as reserved (single-cycle, result 0, carry 0).

Verification (WIDTH=8)
REQ-034 Add: A=0xF0, B=0x20 -> dataOut=0x10, carry=1, outValid one cycle after accept.
REQ-035 Branch-select and nand: branch-select with A=0x00, B=0x33, pc=0x7C -> 0x33; with A=0x01 -> 0x7C; nand with A=0xFF, B=0x0F -> 0xF0.
REQ-036 Multiply with SEQ_ALU_MUL_EN: A=0x10, B=0x11 -> dataOut=0x10 and carry=1 after 8 cycles; ready=0 throughout; start during BUSY is ignored.
REQ-037 Shift-left: A=0x81, B=0x0A (n=2) -> dataOut=0x04 after 3 cycles; B=0x08 -> 0x81 after 1 cycle.
REQ-038 Reset mid-multiply: rst_n low at cycle 4 -> dataOut=0x00, zero=1, no outValid; set-less-than with A=3, B=5 right after release -> dataOut=0x01.
REQ-039 Multiply without SEQ_ALU_MUL_EN: code 100 -> dataOut=0x00 with outValid after 1 cycle.
